// File: rtl/ad9914_sweep_loader_pkg.sv
// Shared definitions for the AD9914 digital-ramp loader: register map,
// SPI frame format and the sequencer state encoding.
package ad9914_sweep_loader_pkg;

  localparam logic [6:0] REG_DRG_LOWER = 7'h04;
  localparam logic [6:0] REG_DRG_UPPER = 7'h05;
  localparam logic [6:0] REG_DRG_RSTEP = 7'h06;
  localparam logic [6:0] REG_DRG_FSTEP = 7'h07;
  localparam logic [6:0] REG_DRG_RATE  = 7'h08;

  localparam logic SPI_WRITE  = 1'b0;
  localparam int   FRAME_BITS = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP,
    ST_IOUPD,
    ST_DONE
  } state_t;

  // Instruction byte (write flag + address) followed by the 32-bit payload.
  function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [6:0]  addr,
                                                      input logic [31:0] data);
    return {SPI_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/ad9914_spi_frame_tx.sv
// Serialises one 40-bit write frame MSB first: chip-select setup, 40 SCLK
// periods (low half then high half), chip-select hold.
module ad9914_spi_frame_tx
  import ad9914_sweep_loader_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic                  i_go,
  output logic                  o_sclk,
  output logic                  o_sdio,
  output logic                  o_cs_n,
  output logic                  o_frame_done
);

  localparam int              DIVW      = $clog2(2 * SCLK_DIV) + 1;
  localparam logic [DIVW-1:0] HALF_LAST = DIVW'(SCLK_DIV - 1);
  localparam logic [DIVW-1:0] BIT_LAST  = DIVW'(2 * SCLK_DIV - 1);

  state_t                r_phase;
  logic [DIVW-1:0]       r_div;
  logic [5:0]            r_bitcnt;
  logic [FRAME_BITS-1:0] r_shreg;
  logic                  r_sclk;
  logic                  r_sdio;
  logic                  r_cs_n;

  // Frame phase sequencer; sdio only moves on the falling SCLK edge so the
  // rising edge always sees a settled bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= ST_IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_sclk   <= 1'b0;
      r_sdio   <= 1'b0;
      r_cs_n   <= 1'b1;
    end else begin
      case (r_phase)
        ST_IDLE: begin
          if (i_go) begin
            r_phase <= ST_CS_SETUP;
            r_div   <= '0;
            r_shreg <= i_frame;
            r_sdio  <= i_frame[FRAME_BITS-1];
            r_cs_n  <= 1'b0;
          end
        end
        ST_CS_SETUP: begin
          if (r_div == HALF_LAST) begin
            r_phase  <= ST_SHIFT;
            r_div    <= '0;
            r_bitcnt <= 6'(FRAME_BITS - 1);
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        ST_SHIFT: begin
          if (r_div == HALF_LAST) r_sclk <= 1'b1;
          if (r_div == BIT_LAST) begin
            r_sclk <= 1'b0;
            r_div  <= '0;
            if (r_bitcnt == 6'd0) begin
              r_phase <= ST_CS_HOLD;
            end else begin
              r_bitcnt <= r_bitcnt - 6'd1;
              r_sdio   <= r_shreg[FRAME_BITS-2];
              r_shreg  <= {r_shreg[FRAME_BITS-2:0], 1'b0};
            end
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        ST_CS_HOLD: begin
          if (r_div == HALF_LAST) begin
            r_phase <= ST_IDLE;
            r_div   <= '0;
            r_cs_n  <= 1'b1;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        default: r_phase <= ST_IDLE;
      endcase
    end
  end

  // Flags the last chip-select-low cycle so the sequencer can time the gap.
  assign o_frame_done = (r_phase == ST_CS_HOLD) && (r_div == HALF_LAST);
  assign o_sclk       = r_sclk;
  assign o_sdio       = r_sdio;
  assign o_cs_n       = r_cs_n;

endmodule

// File: rtl/ad9914_sweep_loader.sv
// Latches one sweep parameter set and writes it to the AD9914 digital-ramp
// registers as five SPI frames, then pulses IO_UPDATE and reports done.
module ad9914_sweep_loader
  import ad9914_sweep_loader_pkg::*;
#(
  parameter int SCLK_DIV     = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int IOUPD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ftw_l,
  input  logic [31:0] ftw_u,
  input  logic [31:0] positive_step,
  input  logic [15:0] positive_rate,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        sdio,
  output logic        cs_n,
  output logic        io_update
);

  localparam int CNT_MAX = (GAP_CYCLES > IOUPD_CYCLES) ? GAP_CYCLES : IOUPD_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1) + 1;
  localparam logic [CNTW-1:0] GAP_LAST   = CNTW'(GAP_CYCLES - 1);
  localparam logic [CNTW-1:0] IOUPD_LAST = CNTW'(IOUPD_CYCLES - 1);

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [CNTW-1:0]       r_cnt;
  logic [31:0]           r_ftw_l;
  logic [31:0]           r_ftw_u;
  logic [31:0]           r_step;
  logic [15:0]           r_rate;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_io_update;

  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_go;
  logic                  w_gap_end;
  logic                  w_frame_done;

  // Frame content selected by the frame index; the falling step and rate
  // reuse the rising values.
  always_comb begin
    w_frame = mk_frame(REG_DRG_LOWER, r_ftw_l);
    case (r_idx)
      3'd1:    w_frame = mk_frame(REG_DRG_UPPER, r_ftw_u);
      3'd2:    w_frame = mk_frame(REG_DRG_RSTEP, r_step);
      3'd3:    w_frame = mk_frame(REG_DRG_FSTEP, r_step);
      3'd4:    w_frame = mk_frame(REG_DRG_RATE, {r_rate, r_rate});
      default: w_frame = mk_frame(REG_DRG_LOWER, r_ftw_l);
    endcase
  end

  // A new frame is launched from the setup state or on the last gap cycle,
  // so the chip-select-high gap is exactly GAP_CYCLES long.
  assign w_gap_end = (r_state == ST_GAP) && (r_cnt == GAP_LAST);
  assign w_go      = (r_state == ST_CS_SETUP) || (w_gap_end && (r_idx != 3'd5));

  ad9914_spi_frame_tx #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame      (w_frame),
    .i_go         (w_go),
    .o_sclk       (sclk),
    .o_sdio       (sdio),
    .o_cs_n       (cs_n),
    .o_frame_done (w_frame_done)
  );

  // Frame sequencing, gap and IO_UPDATE timing, start/busy/done handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ftw_l     <= '0;
      r_ftw_u     <= '0;
      r_step      <= '0;
      r_rate      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_io_update <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ftw_l <= ftw_l;
            r_ftw_u <= ftw_u;
            r_step  <= positive_step;
            r_rate  <= positive_rate;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD:     r_state <= ST_CS_SETUP;
        ST_CS_SETUP: r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_frame_done) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_idx   <= r_idx + 3'd1;
          end
        end
        ST_GAP: begin
          if (w_gap_end) begin
            if (r_idx == 3'd5) begin
              r_state     <= ST_IOUPD;
              r_io_update <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_state <= ST_SHIFT;
            end
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        ST_IOUPD: begin
          if (r_cnt == IOUPD_LAST) begin
            r_io_update <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign io_update = r_io_update;

endmodule

// File: tb/tb_ad9914_sweep_loader.sv
// Bench for the AD9914 sweep loader: schedule-based reference model checked
// every cycle, plus an SPI decoder compared against hand-computed frames.
module tb_ad9914_sweep_loader;

  localparam int D = 2;
  localparam int G = 4;
  localparam int U = 8;
  localparam int P = 82 * D + G;     // one frame plus its gap
  localparam int L = 5 * P + U + 2;  // start-to-done latency

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ftw_l = '0;
  logic [31:0] ftw_u = '0;
  logic [31:0] step = '0;
  logic [15:0] rate = '0;
  logic        busy, done, sclk, sdio, cs_n, io_update;

  ad9914_sweep_loader #(
    .SCLK_DIV     (D),
    .GAP_CYCLES   (G),
    .IOUPD_CYCLES (U)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ftw_l         (ftw_l),
    .ftw_u         (ftw_u),
    .positive_step (step),
    .positive_rate (rate),
    .busy          (busy),
    .done          (done),
    .sclk          (sclk),
    .sdio          (sdio),
    .cs_n          (cs_n),
    .io_update     (io_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the accepted parameter set and its accept cycle.
  bit          m_act = 0;
  int          m_A = 0;
  logic [39:0] m_fr [5];

  function automatic void model(input int t, output logic ecs, output logic esclk,
                                output logic esdio, output logic eio,
                                output logic ebusy, output logic edone, output bit sv);
    int u, f, r, s;
    ecs = 1'b1; esclk = 1'b0; esdio = 1'b0; eio = 1'b0; ebusy = 1'b0; edone = 1'b0; sv = 0;
    if (t < 0 || t > L) return;
    ebusy = (t < L);
    edone = (t == L);
    u = t - 2;
    if (u >= 0 && u < 5 * P) begin
      f = u / P;
      r = u % P;
      if (r < 82 * D) begin
        ecs = 1'b0;
        sv  = 1;
        if (r < D) esdio = m_fr[f][39];
        else if (r < 81 * D) begin
          s     = r - D;
          esclk = ((s % (2 * D)) >= D);
          esdio = m_fr[f][39 - s / (2 * D)];
        end else esdio = m_fr[f][0];
      end
    end else if (u >= 5 * P && u < 5 * P + U) begin
      eio = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    logic ecs, esclk, esdio, eio, ebusy, edone;
    bit sv;
    model(m_act ? (cyc - m_A) : -1, ecs, esclk, esdio, eio, ebusy, edone, sv);
    chk("cs_n", cs_n, ecs);
    chk("sclk", sclk, esclk);
    chk("io_update", io_update, eio);
    chk("busy", busy, ebusy);
    chk("done", done, edone);
    if (sv) chk("sdio", sdio, esdio);
  end

  // SPI decoder.
  logic [39:0] mon_sh = '0;
  int          mon_edges = 0;
  int          mon_fall = 0;
  logic [39:0] q_fr [$];
  int          q_edges [$];
  int          q_low [$];
  int          done_cnt = 0;
  int          io_cnt = 0;

  always @(negedge cs_n) begin
    mon_sh = '0;
    mon_edges = 0;
    mon_fall = cyc;
  end
  always @(posedge sclk) if (cs_n === 1'b0) begin
    mon_sh = {mon_sh[38:0], sdio};
    mon_edges++;
  end
  always @(posedge cs_n) begin
    q_fr.push_back(mon_sh);
    q_edges.push_back(mon_edges);
    q_low.push_back(cyc - mon_fall);
  end
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (io_update === 1'b1) io_cnt++;
  end

  task automatic clear_mon();
    q_fr.delete();
    q_edges.delete();
    q_low.delete();
    done_cnt = 0;
    io_cnt = 0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [15:0] d);
    @(negedge clk);
    ftw_l = a; ftw_u = b; step = c; rate = d; start = 1'b1;
    m_fr[0] = {8'h04, a};
    m_fr[1] = {8'h05, b};
    m_fr[2] = {8'h06, c};
    m_fr[3] = {8'h07, c};
    m_fr[4] = {8'h08, d, d};
    m_A = cyc + 1;
    m_act = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s done_seen", nm), done, 1'b1);
    chk($sformatf("%s latency", nm), cyc - m_A, 850);
  endtask

  task automatic wait_t(input int t);
    int n;
    n = 0;
    while (cyc != m_A + t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_t reached", cyc - m_A, t);
  endtask

  task automatic check_seq(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] d4);
    logic [39:0] ex [5];
    ex[0] = {8'h04, d0};
    ex[1] = {8'h05, d1};
    ex[2] = {8'h06, d2};
    ex[3] = {8'h07, d3};
    ex[4] = {8'h08, d4};
    chk($sformatf("%s nframes", nm), q_fr.size(), 5);
    for (int i = 0; i < 5 && i < q_fr.size(); i++) begin
      chk($sformatf("%s F%0d word", nm, i), q_fr[i], ex[i]);
      chk($sformatf("%s F%0d edges", nm, i), q_edges[i], 40);
      chk($sformatf("%s F%0d cs_low", nm, i), q_low[i], 164);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle with no start.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (100) @(negedge clk);
    chk("idle cs_n", cs_n, 1'b1);
    chk("idle sclk", sclk, 1'b0);
    chk("idle io_update", io_update, 1'b0);
    chk("idle busy", busy, 1'b0);
    chk("idle done", done, 1'b0);
    chk("idle frames", q_fr.size(), 0);

    // Nominal load.
    clear_mon();
    launch(32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 16'h0032);
    wait_done("nominal");
    repeat (5) @(negedge clk);
    check_seq("nominal", 32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 32'h0000A5A5, 32'h00320032);
    chk("nominal done pulses", done_cnt, 1);
    chk("nominal io_update width", io_cnt, 8);

    // Inputs change right after acceptance.
    clear_mon();
    launch(32'hDEADBEEF, 32'h00000001, 32'h80000000, 16'hFFFF);
    ftw_l = 32'h11111111; ftw_u = 32'h22222222; step = 32'h33333333; rate = 16'h4444;
    wait_done("latch");
    repeat (5) @(negedge clk);
    check_seq("latch", 32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'h80000000, 32'hFFFFFFFF);

    // start pulsed in the middle of F2.
    clear_mon();
    launch(32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 16'h0032);
    wait_t(2 + 2 * P + 50);
    ftw_l = 32'hCAFEF00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    repeat (30) @(negedge clk);
    check_seq("busy_start", 32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 32'h0000A5A5, 32'h00320032);
    chk("busy_start done pulses", done_cnt, 1);
    chk("busy_start idle busy", busy, 1'b0);

    // Asynchronous reset during F1 shift while sclk is high.
    clear_mon();
    launch(32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 16'h0032);
    wait_t(174);
    chk("pre-reset sclk", sclk, 1'b1);
    chk("pre-reset cs_n", cs_n, 1'b0);
    #1;
    rst_n = 1'b0;
    m_act = 0;
    #1;
    chk("async reset cs_n", cs_n, 1'b1);
    chk("async reset sclk", sclk, 1'b0);
    chk("async reset busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    launch(32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 16'h0032);
    wait_done("after_reset");
    repeat (5) @(negedge clk);
    check_seq("after_reset", 32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 32'h0000A5A5, 32'h00320032);

    // Back-to-back: start in the cycle after done.
    clear_mon();
    launch(32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 16'h0032);
    wait_done("b2b first");
    clear_mon();
    launch(32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 16'h0032);
    chk("b2b accepted busy", busy, 1'b1);
    wait_done("b2b second");
    repeat (5) @(negedge clk);
    check_seq("b2b", 32'h12345678, 32'h9ABCDEF0, 32'h0000A5A5, 32'h0000A5A5, 32'h00320032);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
